// File: rtl/bitonic_pkg.sv
// bitonic_pkg: shared types and sizing helpers for the iterative bitonic sorter
package bitonic_pkg;
    typedef enum logic [1:0] {IDLE, SORT, DONE} sort_state_t;

    function automatic int num_stages(input int depth);
        return depth * (depth + 1) / 2;
    endfunction

    // Width needed to hold the stage counters p (1..depth) and j (0..depth-1).
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/bitonic_cmp_swap.sv
// bitonic_cmp_swap: combinational compare-exchange of one key pair
// Ports: a/b  keys at the lower/higher index
//        dir  0 = lower index gets the smaller key, 1 = lower index gets the larger key
//        lo/hi keys written back to the lower/higher index
module bitonic_cmp_swap #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  dir,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);
    logic a_gt, a_lt, swap;

    assign a_gt = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);
    assign a_lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
    // Strict compares only, so equal keys are never exchanged.
    assign swap = dir ? a_lt : a_gt;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;
endmodule

// File: rtl/bitonic_sorter_iter.sv
// bitonic_sorter_iter: iterative bitonic sorter, one compare-exchange stage per clock
// Ports: clk/reset            clock, synchronous active-high reset
//        in_valid/in_ready    input handshake for data_in (N packed keys) and in_dir
//        in_dir               0 = ascending, 1 = descending
//        out_valid/out_ready  output handshake for data_out (sorted, same packing)
//        busy                 high while stages are being applied
module bitonic_sorter_iter
    import bitonic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 2,
    parameter int SIGNED      = 0
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [(1<<BLOCK_DEPTH)*DATA_WIDTH-1:0]    data_in,
    input  logic                                      in_dir,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [(1<<BLOCK_DEPTH)*DATA_WIDTH-1:0]    data_out,
    output logic                                      busy
);
    localparam int N  = 1 << BLOCK_DEPTH;
    localparam int H  = N / 2;
    localparam int CW = cnt_width(BLOCK_DEPTH);
    localparam logic [CW-1:0] P_LAST = CW'(BLOCK_DEPTH);

    sort_state_t                  state_q, state_d;
    logic [N-1:0][DATA_WIDTH-1:0] work_q, work_d, staged;
    logic                         dir_q, dir_d;
    logic [CW-1:0]                p_q, p_d, j_q, j_d;
    logic [H-1:0][DATA_WIDTH-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
    logic [H-1:0]                 cmp_dir;
    int                           lo_idx [H];
    int                           hi_idx [H];
    logic                         accept;

    // Comparator c serves the pair whose lower index is c with a zero inserted at bit j.
    always_comb begin
        for (int c = 0; c < H; c++) begin
            lo_idx[c]  = ((c >> j_q) << (j_q + 1'b1)) | (c & ((1 << j_q) - 1));
            hi_idx[c]  = lo_idx[c] | (1 << j_q);
            cmp_a[c]   = work_q[lo_idx[c][BLOCK_DEPTH-1:0]];
            cmp_b[c]   = work_q[hi_idx[c][BLOCK_DEPTH-1:0]];
            // Bit p of the index picks the sub-sequence direction until the final merge.
            cmp_dir[c] = ((p_q < P_LAST) && lo_idx[c][p_q]) ^ dir_q;
        end
    end

    for (genvar g = 0; g < H; g++) begin : g_cmp
        bitonic_cmp_swap #(
            .DATA_WIDTH(DATA_WIDTH),
            .SIGNED    (SIGNED)
        ) u_cmp (
            .a  (cmp_a[g]),
            .b  (cmp_b[g]),
            .dir(cmp_dir[g]),
            .lo (cmp_lo[g]),
            .hi (cmp_hi[g])
        );
    end

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = state_q == DONE;
    assign busy      = state_q == SORT;
    assign data_out  = work_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        staged = work_q;
        for (int c = 0; c < H; c++) begin
            staged[lo_idx[c][BLOCK_DEPTH-1:0]] = cmp_lo[c];
            staged[hi_idx[c][BLOCK_DEPTH-1:0]] = cmp_hi[c];
        end
        state_d = state_q;
        work_d  = work_q;
        dir_d   = dir_q;
        p_d     = p_q;
        j_d     = j_q;
        if (accept) begin
            work_d  = data_in;
            dir_d   = in_dir;
            p_d     = CW'(1);
            j_d     = '0;
            state_d = SORT;
        end else if (state_q == SORT) begin
            work_d = staged;
            if (j_q != '0) begin
                j_d = j_q - 1'b1;
            end else if (p_q < P_LAST) begin
                p_d = p_q + 1'b1;
                j_d = p_q;
            end else begin
                state_d = DONE;
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            dir_q   <= 1'b0;
            p_q     <= CW'(1);
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
            p_q     <= p_d;
            j_q     <= j_d;
        end
    end
endmodule

// File: tb/tb_bitonic_sorter_iter.sv
// tb_bitonic_sorter_iter: randomized self-checking bench for three sorter configurations
module tb_bitonic_sorter_iter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_dir = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  iv = 3'b000;
    logic [2:0]  ir, ov, bz;
    logic [63:0] din = '0;
    logic [31:0] do0, do1;
    logic [63:0] do2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    bitonic_sorter_iter #(.DATA_WIDTH(8), .BLOCK_DEPTH(2), .SIGNED(0)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(din[31:0]),
        .in_dir(in_dir), .out_valid(ov[0]), .out_ready(out_ready), .data_out(do0), .busy(bz[0]));
    bitonic_sorter_iter #(.DATA_WIDTH(8), .BLOCK_DEPTH(2), .SIGNED(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(din[31:0]),
        .in_dir(in_dir), .out_valid(ov[1]), .out_ready(out_ready), .data_out(do1), .busy(bz[1]));
    bitonic_sorter_iter #(.DATA_WIDTH(8), .BLOCK_DEPTH(3), .SIGNED(0)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(din),
        .in_dir(in_dir), .out_valid(ov[2]), .out_ready(out_ready), .data_out(do2), .busy(bz[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dout(input int w);
        return (w == 0) ? {32'b0, do0} : (w == 1) ? {32'b0, do1} : do2;
    endfunction

    // Reference: plain bubble sort on integer key values.
    function automatic logic [63:0] ref_sort(input logic [63:0] d, input int n, input bit sgn, input bit desc);
        int          k [8];
        int          t;
        logic [7:0]  b;
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) begin
            b = d[8*i +: 8];
            k[i] = sgn ? int'($signed(b)) : int'(b);
        end
        for (int a = 0; a < n; a++)
            for (int i = 0; i < n - 1 - a; i++)
                if (desc ? (k[i] < k[i+1]) : (k[i] > k[i+1])) begin
                    t = k[i];
                    k[i] = k[i+1];
                    k[i+1] = t;
                end
        for (int i = 0; i < n; i++) r[8*i +: 8] = k[i][7:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sort_one(input int w, input logic [63:0] d, input logic dir, output logic [63:0] res);
        int n;
        din = d;
        in_dir = dir;
        iv[w] = 1'b1;
        n = 0;
        while (!ir[w] && n < 50) begin
            step();
            n++;
        end
        chk("accept_wait", 64'(n < 50), 64'd1);
        step();
        iv[w] = 1'b0;
        chk("busy_sort", 64'(bz[w]), 64'd1);
        chk("ready_sort", 64'(ir[w]), 64'd0);
        n = 0;
        while (!ov[w] && n < 100) begin
            step();
            n++;
        end
        chk("latency", 64'(n), 64'((w == 2) ? 6 : 3));
        res = dout(w);
    endtask

    initial begin
        logic [63:0] r, hold;
        int          n;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_in_ready", 64'(ir[0]), 64'd1);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_busy", 64'(bz[0]), 64'd0);
        chk("rst_data_out", 64'(do0), 64'd0);

        sort_one(0, 64'h02040103, 1'b0, r);
        chk("asc_d2", r, 64'h04030201);
        step();
        chk("idle_in_ready", 64'(ir[0]), 64'd1);
        chk("idle_out_valid", 64'(ov[0]), 64'd0);
        sort_one(0, 64'h02040103, 1'b1, r);
        chk("desc_d2", r, 64'h01020304);
        sort_one(1, 64'h00FF807F, 1'b0, r);
        chk("signed_asc", r, 64'h7F00FF80);
        sort_one(0, 64'h00FF807F, 1'b0, r);
        chk("unsigned_asc", r, 64'hFF807F00);
        sort_one(2, 64'h05FF000005000505, 1'b0, r);
        chk("dup_d3", r, 64'hFF05050505000000);

        // Backpressure followed by a same-cycle handoff.
        step();
        out_ready = 1'b0;
        sort_one(0, 64'h11332200, 1'b0, hold);
        chk("bp_result", hold, 64'h33221100);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stable", 64'(do0), hold);
            chk("bp_in_ready", 64'(ir[0]), 64'd0);
            chk("bp_out_valid", 64'(ov[0]), 64'd1);
        end
        din = 64'h40104020;
        in_dir = 1'b1;
        iv[0] = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("handoff_ready", 64'(ir[0]), 64'd1);
        step();
        iv[0] = 1'b0;
        chk("handoff_out_valid", 64'(ov[0]), 64'd0);
        chk("handoff_busy", 64'(bz[0]), 64'd1);
        n = 0;
        while (!ov[0] && n < 100) begin
            step();
            n++;
        end
        chk("handoff_latency", 64'(n), 64'd3);
        chk("handoff_result", 64'(do0), 64'h10204040);

        // Reset during the second SORT cycle.
        din = 64'h01020304;
        in_dir = 1'b0;
        iv[0] = 1'b1;
        chk("pre_rst_ready", 64'(ir[0]), 64'd1);
        step();
        iv[0] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(bz[0]), 64'd0);
        chk("mid_rst_out_valid", 64'(ov[0]), 64'd0);
        chk("mid_rst_in_ready", 64'(ir[0]), 64'd1);
        chk("mid_rst_data_out", 64'(do0), 64'd0);
        sort_one(0, 64'h01020304, 1'b0, r);
        chk("post_rst_sort", r, 64'h04030201);

        for (int t = 0; t < 30; t++) begin
            int          w;
            logic        dr;
            logic [63:0] d;
            w = int'($urandom_range(0, 2));
            dr = 1'($urandom_range(0, 1));
            d = {$urandom(), $urandom()};
            if (w != 2) d[63:32] = '0;
            sort_one(w, d, dr, r);
            chk("random", r, ref_sort(d, (w == 2) ? 8 : 4, w == 1, dr));
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
